hps_spi_master: RTL and testbench

- 16-bit SPI master, mode 1 (CPOL=0, CPHA=1). It is the initiator end of the HPS word link that the FPGA-side SPI slave serves.
- Used as the host-side bus model in the system bench. Also used in-fabric to drive an external SPI slave with the same word protocol.
- Accepts one word per start/busy handshake, shifts it out MSB-first while capturing MISO, and returns the received word with a one-cycle valid pulse.
- Optional chip-select hold allows multi-word bursts under a single CS assertion.

---
 rtl/hps_spi_master_if.sv | 23 ++
 rtl/hps_spi_master.sv | 116 +++++++++++
 tb/tb_hps_spi_master.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hps_spi_master_if.sv
// Host-side word handshake of the HPS SPI master: request/busy on the way in,
// received word with a one-cycle valid strobe on the way out.
interface hps_spi_master_if #(
  parameter int N = 16
) ();
  logic         start;
  logic         keep_cs;
  logic         cs_release;
  logic [N-1:0] tx_data;
  logic         busy;
  logic [N-1:0] rx_data;
  logic         rx_valid;

  modport master (
    output start, keep_cs, cs_release, tx_data,
    input  busy, rx_data, rx_valid
  );

  modport slave (
    input  start, keep_cs, cs_release, tx_data,
    output busy, rx_data, rx_valid
  );
endinterface

// File: rtl/hps_spi_master.sv
// Mode-1 (CPOL=0, CPHA=1) SPI master, one N-bit word per start/busy handshake,
// with optional chip-select hold for multi-word bursts.
module hps_spi_master #(
  parameter int N       = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  hps_spi_master_if.slave  bus,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, GAP, HELD} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  tx_sr;
  logic [N-1:0]  rx_sr;
  logic          keep_q;

  logic half_end, gap_end, accept, rise, fall, last_low, release_cs;

  always_comb begin
    half_end   = (cnt == CW'(CLK_DIV - 1));
    gap_end    = (cnt == CW'(CS_GAP - 1));
    accept     = ((state == IDLE) || (state == HELD)) && bus.start;
    release_cs = (state == HELD) && !bus.start && bus.cs_release;
    // The low half-period after the last falling edge still belongs to SHIFT,
    // so TAIL only starts once that half-period has elapsed.
    last_low   = (state == SHIFT) && half_end && !spi_clk && (bit_cnt == BW'(N));
    rise       = half_end && ((state == SETUP) ||
                 ((state == SHIFT) && !spi_clk && (bit_cnt != BW'(N))));
    fall       = (state == SHIFT) && half_end && spi_clk;

    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   if (half_end) next_state = SHIFT;
      SHIFT:   if (last_low) next_state = TAIL;
      TAIL:    if (half_end) next_state = keep_q ? HELD : GAP;
      GAP:     if (gap_end) next_state = IDLE;
      HELD: begin
        if (accept)          next_state = SETUP;
        else if (release_cs) next_state = GAP;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.busy = !((state == IDLE) || (state == HELD));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // One divider serves both the half-period timing and the CS gap.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if ((next_state != state) || (state == IDLE) || (state == HELD) ||
                 ((state == SHIFT) && half_end)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      keep_q       <= 1'b0;
      spi_clk      <= 1'b0;
      spi_mosi     <= 1'b0;
      spi_cs       <= 1'b1;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else begin
      bus.rx_valid <= 1'b0;
      if (accept) begin
        tx_sr   <= bus.tx_data;
        keep_q  <= bus.keep_cs;
        bit_cnt <= '0;
        spi_cs  <= 1'b0;
      end
      if (rise) begin
        spi_clk  <= 1'b1;
        spi_mosi <= tx_sr[N-1];
        tx_sr    <= {tx_sr[N-2:0], 1'b0};
      end
      if (fall) begin
        spi_clk <= 1'b0;
        rx_sr   <= {rx_sr[N-2:0], spi_miso};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if ((state == TAIL) && half_end) begin
        bus.rx_valid <= 1'b1;
        bus.rx_data  <= rx_sr;
        if (!keep_q) spi_cs <= 1'b1;
      end
      if (release_cs) spi_cs <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hps_spi_master.sv
// Scoreboarded bench for hps_spi_master: directed words with hand-computed
// results, loopback or a mode-1 slave model on MISO.
module tb_hps_spi_master;

  logic sys_clk;
  logic reset_n;
  logic spi_clk, spi_mosi, spi_miso, spi_cs;

  hps_spi_master_if #(.N(16)) bus ();

  hps_spi_master #(.N(16), .CLK_DIV(2), .CS_GAP(2)) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs   (spi_cs)
  );

  typedef struct {
    logic [15:0] data;
    int          t;
    bit          slv;
    logic [15:0] sexp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, rx_cnt = 0, rises = 0, falls = 0, cs_rise = 0;
  int   mosi_bad = 0, clk_cs_bad = 0;

  bit          loop_mode = 1'b1;
  logic [15:0] s_word = 16'h0000;
  logic [15:0] s_rx = 16'h0000;
  logic [3:0]  s_idx = 4'd0;
  logic        s_miso = 1'b0;

  assign spi_miso = loop_mode ? spi_mosi : s_miso;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // Mode-1 slave: drive on rising spi_clk, capture on falling spi_clk.
  initial forever begin
    @(posedge spi_clk or negedge spi_cs);
    if (!spi_clk) s_idx = 4'd0;
    else begin
      s_miso = s_word[4'd15 - s_idx];
      s_idx  = s_idx + 4'd1;
    end
  end

  initial forever begin
    @(negedge spi_clk);
    s_rx = {s_rx[14:0], spi_mosi};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every rx_valid, tracks SPI pin rules.
  initial begin
    logic pclk, pmosi, pcs;
    exp_t e;
    pclk = 1'b0; pmosi = 1'b0; pcs = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (!reset_n) begin
        rises = 0;
        falls = 0;
      end else begin
        if (spi_clk && !pclk) rises++;
        if (!spi_clk && pclk) falls++;
        if ((spi_mosi !== pmosi) && !(spi_clk && !pclk)) mosi_bad++;
        if ((spi_clk !== pclk) && spi_cs) clk_cs_bad++;
        if (spi_cs && !pcs) cs_rise++;
        if (bus.rx_valid) begin
          rx_cnt++;
          if (q.size() == 0) begin
            check("unexpected_rx_valid", 32'(bus.rx_valid), 32'd0);
          end else begin
            e = q.pop_front();
            check("rx_data", 32'(bus.rx_data), 32'(e.data));
            check("rx_latency", 32'(cyc - e.t), 32'd69);
            check("rise_count", 32'(rises), 32'd16);
            check("fall_count", 32'(falls), 32'd16);
            if (e.slv) check("slave_capture", 32'(s_rx), 32'(e.sexp));
          end
          rises = 0;
          falls = 0;
        end
      end
      pclk = spi_clk; pmosi = spi_mosi; pcs = spi_cs;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (bus.busy && i < 300) begin tick(); i++; end
    if (i >= 300) check(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_rx(input int target, input string tag);
    int i = 0;
    while (rx_cnt < target && i < 300) begin tick(); i++; end
    if (rx_cnt < target) check(tag, 32'(rx_cnt), 32'(target));
  endtask

  task automatic send(input logic [15:0] d, input bit keep, input bit rel,
                      input logic [15:0] exp, input bit slv, input logic [15:0] sexp);
    wait_idle("send_wait_idle");
    bus.start      = 1'b1;
    bus.tx_data    = d;
    bus.keep_cs    = keep;
    bus.cs_release = rel;
    q.push_back('{data: exp, t: cyc, slv: slv, sexp: sexp});
    tick();
    bus.start      = 1'b0;
    bus.cs_release = 1'b0;
  endtask

  initial begin
    int r0, c0, i;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.keep_cs    = 1'b0;
    bus.cs_release = 1'b0;
    bus.tx_data    = '0;
    repeat (3) tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_cs", 32'(spi_cs), 32'd1);
    check("reset_clk", 32'(spi_clk), 32'd0);
    check("reset_mosi", 32'(spi_mosi), 32'd0);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Loopback single word, then the CS gap.
    r0 = rx_cnt;
    send(16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 1'b0, 16'h0);
    wait_rx(r0 + 1, "loopback_rx_timeout");
    check("gap0_cs", 32'(spi_cs), 32'd1);
    check("gap0_busy", 32'(bus.busy), 32'd1);
    tick();
    check("gap1_cs", 32'(spi_cs), 32'd1);
    check("gap1_busy", 32'(bus.busy), 32'd1);
    tick();
    check("gap_end_busy", 32'(bus.busy), 32'd0);

    // Mode-1 slave returning 0x5AA5.
    loop_mode = 1'b0;
    s_word    = 16'h5AA5;
    r0 = rx_cnt;
    send(16'h1234, 1'b0, 1'b0, 16'h5AA5, 1'b1, 16'h1234);
    wait_rx(r0 + 1, "slave_rx_timeout");
    wait_idle("slave_idle");
    loop_mode = 1'b1;

    // Three-word burst under one CS assertion.
    r0 = rx_cnt; c0 = cs_rise;
    send(16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 16'h0);
    wait_rx(r0 + 1, "burst1_timeout");
    check("held_busy", 32'(bus.busy), 32'd0);
    check("held_cs", 32'(spi_cs), 32'd0);
    send(16'h0002, 1'b1, 1'b0, 16'h0002, 1'b0, 16'h0);
    wait_rx(r0 + 2, "burst2_timeout");
    check("burst_cs_rises_mid", 32'(cs_rise - c0), 32'd0);
    send(16'h0003, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0);
    wait_rx(r0 + 3, "burst3_timeout");
    wait_idle("burst_idle");
    check("burst_cs_rises_end", 32'(cs_rise - c0), 32'd1);

    // HELD, then a cs_release pulse.
    r0 = rx_cnt;
    send(16'h00FF, 1'b1, 1'b0, 16'h00FF, 1'b0, 16'h0);
    wait_rx(r0 + 1, "held_rx_timeout");
    bus.cs_release = 1'b1;
    tick();
    bus.cs_release = 1'b0;
    check("rel_cs", 32'(spi_cs), 32'd1);
    check("rel_busy0", 32'(bus.busy), 32'd1);
    tick();
    check("rel_busy1", 32'(bus.busy), 32'd1);
    tick();
    check("rel_busy_end", 32'(bus.busy), 32'd0);

    // start and cs_release together in HELD: start wins.
    r0 = rx_cnt;
    send(16'h8001, 1'b1, 1'b0, 16'h8001, 1'b0, 16'h0);
    wait_rx(r0 + 1, "held2_rx_timeout");
    c0 = cs_rise;
    send(16'h7FFE, 1'b0, 1'b1, 16'h7FFE, 1'b0, 16'h0);
    check("start_wins_cs", 32'(spi_cs), 32'd0);
    check("start_wins_busy", 32'(bus.busy), 32'd1);
    wait_rx(r0 + 2, "start_wins_timeout");
    check("start_wins_cs_rises", 32'(cs_rise - c0), 32'd1);
    wait_idle("start_wins_idle");

    // start held high through a frame: one frame, tx_data changes ignored.
    r0 = rx_cnt;
    bus.start   = 1'b1;
    bus.keep_cs = 1'b0;
    bus.tx_data = 16'hC0DE;
    q.push_back('{data: 16'hC0DE, t: cyc, slv: 1'b0, sexp: 16'h0});
    tick();
    bus.tx_data = 16'hFFFF;
    repeat (58) tick();
    bus.start = 1'b0;
    wait_rx(r0 + 1, "spam_rx_timeout");
    wait_idle("spam_idle");
    repeat (20) tick();
    check("spam_frame_count", 32'(rx_cnt - r0), 32'd1);

    // Reset at bit 7 aborts the frame.
    send(16'h6E19, 1'b0, 1'b0, 16'h6E19, 1'b0, 16'h0);
    i = 0;
    while (rises < 8 && i < 200) begin tick(); i++; end
    check("abort_reached_bit7", 32'(rises), 32'd8);
    reset_n = 1'b0;
    #1;
    check("abort_cs", 32'(spi_cs), 32'd1);
    check("abort_clk", 32'(spi_clk), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    q.delete();
    r0 = rx_cnt;
    repeat (5) tick();
    check("abort_no_rx", 32'(rx_cnt), 32'(r0));
    reset_n = 1'b1;
    tick();
    send(16'h3C96, 1'b0, 1'b0, 16'h3C96, 1'b0, 16'h0);
    wait_rx(r0 + 1, "post_reset_timeout");
    wait_idle("post_reset_idle");

    check("mosi_only_on_rise", 32'(mosi_bad), 32'd0);
    check("clk_quiet_cs_high", 32'(clk_cs_bad), 32'd0);
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
